// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state encoding,
// default operand width and a low-bit mask helper.
package shift_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Mask with the k least-significant bits set (k in 0..31).
  function automatic logic [31:0] low_mask(input int k);
    low_mask = (32'h1 << k) - 32'h1;
  endfunction

endpackage

// File: rtl/shift_add_sequencer_cla.sv
// Generic carry-lookahead adder: generate/propagate carry recurrence that
// synthesis flattens into lookahead logic; used as the sequencer's only adder.
module carry_lookahead_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] gen_s;
  logic [WIDTH-1:0] prop_s;
  logic [WIDTH:0]   carry_s;

  // Bitwise generate and propagate terms.
  always_comb begin
    gen_s  = a & b;
    prop_s = a ^ b;
  end

  // Carry chain c[i+1] = g[i] | p[i] & c[i], then the sum bits.
  always_comb begin : carry_chain
    logic [WIDTH:0] c_v;
    c_v    = {(WIDTH+1){1'b0}};
    c_v[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c_v[i+1] = gen_s[i] | (prop_s[i] & c_v[i]);
    end
    carry_s = c_v;
  end

  assign sum  = prop_s ^ carry_s[WIDTH-1:0];
  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/shift_add_sequencer.sv
// Sequential unsigned shift-add multiplier with valid/ready handshakes.
// Define SHIFT_ADD_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_sequencer
  import shift_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             state_r;
  state_e             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   a_next_s;
  logic [2*WIDTH:0]   p_r;
  logic [2*WIDTH:0]   p_next_s;
  logic [2*WIDTH:0]   p_shift_s;
  logic [2*WIDTH:0]   p_done_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_next_s;
  logic               last_s;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;
  logic               ready_r;
  logic               busy_r;
  logic               valid_r;

  carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (p_r[2*WIDTH-1:WIDTH]),
    .b    (a_r),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // One iteration: conditional add of A into the upper half, then shift right.
  always_comb begin
    if (p_r[0]) begin
      p_shift_s = {1'b0, cout_s, sum_s, p_r[WIDTH-1:1]};
    end else begin
      p_shift_s = {1'b0, p_r[2*WIDTH:1]};
    end
  end

`ifdef SHIFT_ADD_EARLY_TERM_EN
  // k = bits still unconsumed after this iteration; stop once they are all zero
  // and apply the k pending shifts at once (k = 0 on the final iteration).
  always_comb begin : early_term
    logic [31:0] mask_v;
    mask_v   = 32'h0;
    last_s   = 1'b0;
    p_done_s = p_shift_s;
    for (int k = 0; k < WIDTH; k++) begin
      if (cnt_r == CW'(WIDTH - 1 - k)) begin
        mask_v   = low_mask(k);
        last_s   = ((p_shift_s[WIDTH-1:0] & mask_v[WIDTH-1:0]) == {WIDTH{1'b0}});
        p_done_s = p_shift_s >> k;
      end else begin
        mask_v = mask_v;
      end
    end
  end
`else
  // Fixed latency: the last iteration is always number WIDTH-1.
  always_comb begin
    last_s   = (cnt_r == CW'(WIDTH - 1));
    p_done_s = p_shift_s;
  end
`endif

  // Next-state and datapath update selection.
  always_comb begin
    state_s    = state_r;
    a_next_s   = a_r;
    p_next_s   = p_r;
    cnt_next_s = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i && ready_r) begin
          state_s    = BUSY;
          a_next_s   = multiplicand_i;
          p_next_s   = {{(WIDTH+1){1'b0}}, multiplier_i};
          cnt_next_s = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s  = DONE;
          p_next_s = p_done_s;
        end else begin
          p_next_s   = p_shift_s;
          cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (result_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      p_r     <= {(2*WIDTH+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_next_s;
      p_r     <= p_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s == BUSY);
      valid_r <= (state_s == DONE);
    end
  end

  assign req_ready_o    = ready_r;
  assign busy_o         = busy_r;
  assign result_valid_o = valid_r;
  assign result_o       = p_r[2*WIDTH-1:0];

endmodule
